// File: rtl/of_tcam_pkg.sv
// Shared definitions for the OpenFlow wildcard flow-table matcher:
// default widths, FSM state encoding and elaboration-time helper functions.
package of_tcam_pkg;

  localparam int OF_HEADER_REG_WIDTH  = 240;
  localparam int OF_NUM_ENTRIES       = 32;
  localparam int OF_ACTION_DATA_WIDTH = 48;
  localparam int OF_ACTION_CTRL_WIDTH = 16;
  localparam int OF_SLICE_WIDTH       = 32;
  localparam int OF_COUNT_WIDTH       = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } tcam_state_e;

  // Smallest r with 2**r >= value (address width for a table of 'value' rows).
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Integer division rounded up (number of compare slices for a key).
  function automatic int ceildiv(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/of_tcam_slice.sv
// One SLICE_WIDTH-wide key/mask column of the flow table with NUM_ENTRIES
// rows. Compares the lookup slice against every row and registers the
// per-row match vector, already qualified by the entry valid bits.
module of_tcam_slice
  import of_tcam_pkg::*;
#(
  parameter int SLICE_WIDTH = 32,
  parameter int NUM_ENTRIES = 32,
  parameter int ADDR_BITS   = log2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [ADDR_BITS-1:0]   wr_addr,
  input  logic [SLICE_WIDTH-1:0] wr_key,
  input  logic [SLICE_WIDTH-1:0] wr_mask,
  input  logic                   cmp_en,
  input  logic [SLICE_WIDTH-1:0] cmp_key,
  input  logic [NUM_ENTRIES-1:0] entry_valid,
  output logic [NUM_ENTRIES-1:0] match
);

  logic [SLICE_WIDTH-1:0] key_mem  [NUM_ENTRIES];
  logic [SLICE_WIDTH-1:0] mask_mem [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] match_c;

  // Key/mask storage is deliberately not reset; rows are gated by valid bits.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_mem[wr_addr]  <= wr_key;
      mask_mem[wr_addr] <= wr_mask;
    end
  end

  // Ternary compare of every row against the lookup slice (mask bit 1 = don't care).
  always_comb begin
    match_c = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      match_c[e] = entry_valid[e] &&
                   (((cmp_key ^ key_mem[e]) & ~mask_mem[e]) == '0);
    end
  end

  // Stage-1 register; sees storage as it was before any same-cycle write.
  always_ff @(posedge clk) begin
    if (cmp_en) begin
      match <= match_c;
    end
  end

endmodule

// File: rtl/of_tcam_matcher.sv
// Wildcard flow-table matcher between the header parser and the action
// processor. Two-stage lookup pipeline (slice compare, then AND-reduce and
// lowest-index priority encode), per-entry valid bits, a sequential flush
// engine and hit/miss statistics.
module of_tcam_matcher
  import of_tcam_pkg::*;
#(
  parameter  int CMP_WIDTH   = OF_HEADER_REG_WIDTH,
  parameter  int SLICE_WIDTH = OF_SLICE_WIDTH,
  parameter  int NUM_ENTRIES = OF_NUM_ENTRIES,
  parameter  int DATA_WIDTH  = OF_ACTION_DATA_WIDTH + OF_ACTION_CTRL_WIDTH,
  parameter  int COUNT_WIDTH = OF_COUNT_WIDTH,
  localparam int ADDR_BITS   = log2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   lookup_req,
  input  logic [CMP_WIDTH-1:0]   lookup_key,
  output logic                   lookup_ack,
  output logic                   lookup_hit,
  output logic [ADDR_BITS-1:0]   lookup_addr,
  output logic [DATA_WIDTH-1:0]  lookup_data,
  input  logic                   wr_req,
  input  logic [ADDR_BITS-1:0]   wr_addr,
  input  logic [CMP_WIDTH-1:0]   wr_key,
  input  logic [CMP_WIDTH-1:0]   wr_mask,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_entry_valid,
  output logic                   wr_ack,
  input  logic                   flush_req,
  output logic                   busy,
  input  logic                   counters_clr,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count
);

  localparam int NUM_SLICES = ceildiv(CMP_WIDTH, SLICE_WIDTH);
  localparam int PAD_WIDTH  = NUM_SLICES * SLICE_WIDTH;

  tcam_state_e            state_q;
  tcam_state_e            state_d;
  logic [ADDR_BITS-1:0]   flush_ptr_q;
  logic                   wr_accept;
  logic [NUM_ENTRIES-1:0] valid_q;
  logic [DATA_WIDTH-1:0]  data_mem [NUM_ENTRIES];

  // Pad bits are zero on both the stored and the lookup side, so they always match.
  logic [PAD_WIDTH-1:0]   lookup_key_pad;
  logic [PAD_WIDTH-1:0]   wr_key_pad;
  logic [PAD_WIDTH-1:0]   wr_mask_pad;

  logic [NUM_ENTRIES-1:0] slice_match [NUM_SLICES];
  logic                   s1_valid_q;
  logic [NUM_ENTRIES-1:0] entry_match;
  logic                   s2_hit;
  logic [ADDR_BITS-1:0]   s2_addr;
  logic [DATA_WIDTH-1:0]  s2_data;

  assign lookup_key_pad = PAD_WIDTH'(lookup_key);
  assign wr_key_pad     = PAD_WIDTH'(wr_key);
  assign wr_mask_pad    = PAD_WIDTH'(wr_mask);

  // FSM state register and flush pointer (pointer restarts at 0 whenever idle).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      flush_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FLUSH) begin
        flush_ptr_q <= flush_ptr_q + ADDR_BITS'(1);
      end else begin
        flush_ptr_q <= '0;
      end
    end
  end

  // Next-state: flush walks every entry once, further flush requests are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (flush_req) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_ptr_q == ADDR_BITS'(NUM_ENTRIES - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy while flushing, writes only accepted when idle.
  always_comb begin
    busy      = (state_q == ST_FLUSH);
    wr_accept = wr_req && (state_q == ST_IDLE);
  end

  // Valid bits: written by table updates, cleared one per cycle by the flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (wr_accept) begin
        valid_q[wr_addr] <= wr_entry_valid;
      end
      if (state_q == ST_FLUSH) begin
        valid_q[flush_ptr_q] <= 1'b0;
      end
    end
  end

  // Action data storage, not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      data_mem[wr_addr] <= wr_data;
    end
  end

  // Write acknowledge one cycle after an accepted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= wr_accept;
    end
  end

  // Stage-1 request tracking; clearing it on reset discards in-flight lookups.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= lookup_req;
    end
  end

  for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
    of_tcam_slice #(
      .SLICE_WIDTH (SLICE_WIDTH),
      .NUM_ENTRIES (NUM_ENTRIES),
      .ADDR_BITS   (ADDR_BITS)
    ) u_slice (
      .clk         (clk),
      .wr_en       (wr_accept),
      .wr_addr     (wr_addr),
      .wr_key      (wr_key_pad[s*SLICE_WIDTH +: SLICE_WIDTH]),
      .wr_mask     (wr_mask_pad[s*SLICE_WIDTH +: SLICE_WIDTH]),
      .cmp_en      (lookup_req),
      .cmp_key     (lookup_key_pad[s*SLICE_WIDTH +: SLICE_WIDTH]),
      .entry_valid (valid_q),
      .match       (slice_match[s])
    );
  end

  // Stage 2: AND-reduce slices, pick lowest matching index, read current action data.
  always_comb begin
    entry_match = '1;
    for (int s = 0; s < NUM_SLICES; s++) begin
      entry_match = entry_match & slice_match[s];
    end
    s2_hit  = 1'b0;
    s2_addr = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (entry_match[i]) begin
        s2_hit  = 1'b1;
        s2_addr = ADDR_BITS'(i);
      end
    end
    s2_data = s2_hit ? data_mem[s2_addr] : '0;
  end

  // Result registers; hit/addr/data hold their last value when no result is due.
  always_ff @(posedge clk) begin
    if (reset) begin
      lookup_ack  <= 1'b0;
      lookup_hit  <= 1'b0;
      lookup_addr <= '0;
      lookup_data <= '0;
    end else begin
      lookup_ack <= s1_valid_q;
      if (s1_valid_q) begin
        lookup_hit  <= s2_hit;
        lookup_addr <= s2_addr;
        lookup_data <= s2_data;
      end
    end
  end

  // Statistics advance with the acknowledge; a clear takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (counters_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (s1_valid_q) begin
      if (s2_hit) begin
        hit_count <= hit_count + COUNT_WIDTH'(1);
      end else begin
        miss_count <= miss_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_of_tcam_matcher.sv
// Self-checking bench for of_tcam_matcher: directed scenarios plus a random
// phase, all compared every cycle against a behavioural table model.
module tb_of_tcam_matcher;

  localparam int CW   = 240;
  localparam int NE   = 32;
  localparam int DW   = 64;
  localparam int AW   = 5;
  localparam int CNTW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            lookup_req;
  logic [CW-1:0]   lookup_key;
  logic            lookup_ack;
  logic            lookup_hit;
  logic [AW-1:0]   lookup_addr;
  logic [DW-1:0]   lookup_data;
  logic            wr_req;
  logic [AW-1:0]   wr_addr;
  logic [CW-1:0]   wr_key;
  logic [CW-1:0]   wr_mask;
  logic [DW-1:0]   wr_data;
  logic            wr_entry_valid;
  logic            wr_ack;
  logic            flush_req;
  logic            busy;
  logic            counters_clr;
  logic [CNTW-1:0] hit_count;
  logic [CNTW-1:0] miss_count;

  always #5 clk = ~clk;

  of_tcam_matcher #(
    .CMP_WIDTH   (CW),
    .SLICE_WIDTH (32),
    .NUM_ENTRIES (NE),
    .DATA_WIDTH  (DW),
    .COUNT_WIDTH (CNTW)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .lookup_req     (lookup_req),
    .lookup_key     (lookup_key),
    .lookup_ack     (lookup_ack),
    .lookup_hit     (lookup_hit),
    .lookup_addr    (lookup_addr),
    .lookup_data    (lookup_data),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_key         (wr_key),
    .wr_mask        (wr_mask),
    .wr_data        (wr_data),
    .wr_entry_valid (wr_entry_valid),
    .wr_ack         (wr_ack),
    .flush_req      (flush_req),
    .busy           (busy),
    .counters_clr   (counters_clr),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  // Behavioural table model
  logic [CW-1:0]   m_key  [NE];
  logic [CW-1:0]   m_mask [NE];
  logic [DW-1:0]   m_data [NE];
  bit              m_valid[NE];
  bit              m_flushing;
  int              m_ptr;
  bit              p1_valid;
  bit              p1_hit;
  int              p1_addr;
  logic            exp_ack, exp_hit, exp_wr_ack, exp_busy;
  logic [AW-1:0]   exp_addr;
  logic [DW-1:0]   exp_data;
  logic [CNTW-1:0] exp_hits, exp_misses;

  int tests_run    = 0;
  int tests_failed = 0;

  // Lowest valid entry whose cared-about bits equal the key, or -1.
  function automatic int model_match(input logic [CW-1:0] key);
    for (int i = 0; i < NE; i++) begin
      if (m_valid[i] && (((key ^ m_key[i]) & ~m_mask[i]) == '0)) return i;
    end
    return -1;
  endfunction

  function automatic logic [CW-1:0] rand_key();
    logic [255:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[CW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    chk("lookup_ack",  64'(lookup_ack),  64'(exp_ack));
    chk("lookup_hit",  64'(lookup_hit),  64'(exp_hit));
    chk("lookup_addr", 64'(lookup_addr), 64'(exp_addr));
    chk("lookup_data", lookup_data,      exp_data);
    chk("wr_ack",      64'(wr_ack),      64'(exp_wr_ack));
    chk("busy",        64'(busy),        64'(exp_busy));
    chk("hit_count",   64'(hit_count),   64'(exp_hits));
    chk("miss_count",  64'(miss_count),  64'(exp_misses));
  endtask

  // Advance the model by one cycle for the currently driven inputs, clock, then check.
  task automatic applyStimulus();
    int a;
    if (reset) begin
      for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
      m_flushing = 1'b0; m_ptr = 0; p1_valid = 1'b0;
      exp_ack = 1'b0; exp_hit = 1'b0; exp_addr = '0; exp_data = '0;
      exp_wr_ack = 1'b0; exp_busy = 1'b0; exp_hits = '0; exp_misses = '0;
    end else begin
      if (p1_valid) begin
        exp_ack  = 1'b1;
        exp_hit  = p1_hit;
        exp_addr = p1_hit ? AW'(p1_addr) : '0;
        exp_data = p1_hit ? m_data[p1_addr] : '0;
      end else begin
        exp_ack = 1'b0;
      end
      if (counters_clr) begin
        exp_hits = '0; exp_misses = '0;
      end else if (p1_valid) begin
        if (p1_hit) exp_hits++; else exp_misses++;
      end
      p1_valid = lookup_req;
      if (lookup_req) begin
        a = model_match(lookup_key);
        p1_hit  = (a >= 0);
        p1_addr = (a < 0) ? 0 : a;
      end
      exp_wr_ack = wr_req && !m_flushing;
      if (exp_wr_ack) begin
        m_key[wr_addr]   = wr_key;
        m_mask[wr_addr]  = wr_mask;
        m_data[wr_addr]  = wr_data;
        m_valid[wr_addr] = wr_entry_valid;
      end
      if (m_flushing) begin
        m_valid[m_ptr] = 1'b0;
        m_ptr++;
        if (m_ptr == NE) m_flushing = 1'b0;
      end else if (flush_req) begin
        m_flushing = 1'b1;
        m_ptr = 0;
      end
      exp_busy = m_flushing;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle_inputs();
    reset = 1'b0; lookup_req = 1'b0; lookup_key = '0;
    wr_req = 1'b0; wr_addr = '0; wr_key = '0; wr_mask = '0; wr_data = '0;
    wr_entry_valid = 1'b0; flush_req = 1'b0; counters_clr = 1'b0;
  endtask

  task automatic write_entry(input int addr, input logic [CW-1:0] key,
                             input logic [CW-1:0] mask, input logic [DW-1:0] data,
                             input logic v);
    wr_req = 1'b1; wr_addr = AW'(addr); wr_key = key; wr_mask = mask;
    wr_data = data; wr_entry_valid = v;
    applyStimulus();
    wr_req = 1'b0;
  endtask

  task automatic lookup(input logic [CW-1:0] key);
    lookup_req = 1'b1; lookup_key = key;
    applyStimulus();
    lookup_req = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    logic [CW-1:0] x, k1, k2, y, z, flip;
    logic [CW-1:0] pool[4];
    logic [CW-1:0] fk[NE];
    int busy_cycles, wr_ack_seen;

    // Reset
    idle_inputs();
    reset = 1'b1;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ack",  64'(lookup_ack), 64'd0);

    // Single exact entry hit
    write_entry(3, CW'(8'hA5), '0, 64'h1111, 1'b1);
    lookup(CW'(8'hA5));
    applyStimulus();
    chk("tp1_ack",  64'(lookup_ack),  64'd1);
    chk("tp1_hit",  64'(lookup_hit),  64'd1);
    chk("tp1_addr", 64'(lookup_addr), 64'd3);
    chk("tp1_data", lookup_data,      64'h1111);
    chk("tp1_hits", 64'(hit_count),   64'd1);

    // Lowest index wins; deleting it exposes the next match
    x = rand_key();
    write_entry(2, x, CW'(40'hFF_FFFF_FFFF), 64'h2222, 1'b1);
    write_entry(5, x, '0, 64'h5555, 1'b1);
    lookup(x);
    applyStimulus();
    chk("prio_addr", 64'(lookup_addr), 64'd2);
    write_entry(2, x, CW'(40'hFF_FFFF_FFFF), 64'h2222, 1'b0);
    lookup(x);
    applyStimulus();
    chk("del_addr", 64'(lookup_addr), 64'd5);
    chk("del_data", lookup_data, 64'h5555);
    lookup(x ^ CW'(1));
    applyStimulus();
    chk("del_masked_miss", 64'(lookup_hit), 64'd0);

    // Eight back-to-back lookups alternating hit/miss
    counters_clr = 1'b1;
    applyStimulus();
    counters_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lookup_req = 1'b1;
      lookup_key = (i % 2 == 0) ? CW'(8'hA5) : rand_key();
      applyStimulus();
    end
    lookup_req = 1'b0;
    idle_cycles(2);
    chk("b2b_hits",   64'(hit_count),  64'd4);
    chk("b2b_misses", 64'(miss_count), 64'd4);

    // Write in the lookup cycle: old key matches, new data returned
    k1 = rand_key();
    k2 = rand_key();
    write_entry(7, k1, '0, 64'hAAAA, 1'b1);
    wr_req = 1'b1; wr_addr = AW'(7); wr_key = k2; wr_mask = '0;
    wr_data = 64'hBBBB; wr_entry_valid = 1'b1;
    lookup_req = 1'b1; lookup_key = k1;
    applyStimulus();
    wr_req = 1'b0; lookup_req = 1'b0;
    applyStimulus();
    chk("haz0_hit",  64'(lookup_hit),  64'd1);
    chk("haz0_addr", 64'(lookup_addr), 64'd7);
    chk("haz0_data", lookup_data,      64'hBBBB);
    // Write one cycle after the lookup: match and data both old
    lookup(k2);
    write_entry(7, k1, '0, 64'hCCCC, 1'b1);
    chk("haz1_hit",  64'(lookup_hit),  64'd1);
    chk("haz1_addr", 64'(lookup_addr), 64'd7);
    chk("haz1_data", lookup_data,      64'hBBBB);

    // Mismatch only in the top key bit (last, partial slice)
    y = rand_key();
    flip = '0;
    flip[CW-1] = 1'b1;
    write_entry(0, y, '0, 64'h0F0F, 1'b1);
    lookup(y ^ flip);
    applyStimulus();
    chk("topbit_miss", 64'(lookup_hit), 64'd0);
    lookup(y);
    applyStimulus();
    chk("topbit_hit",  64'(lookup_hit),  64'd1);
    chk("topbit_addr", 64'(lookup_addr), 64'd0);

    // Counter clear wins over a same-cycle increment
    lookup(y);
    counters_clr = 1'b1;
    applyStimulus();
    counters_clr = 1'b0;
    chk("clr_ack",  64'(lookup_ack), 64'd1);
    chk("clr_hits", 64'(hit_count),  64'd0);

    // Random traffic
    for (int i = 0; i < 4; i++) pool[i] = rand_key();
    for (int c = 0; c < 300; c++) begin
      lookup_req     = ($urandom_range(0, 3) != 0);
      lookup_key     = pool[$urandom_range(0, 3)] ^ CW'($urandom_range(0, 1) << $urandom_range(0, 7));
      wr_req         = ($urandom_range(0, 3) == 0);
      wr_addr        = AW'($urandom_range(0, 7));
      wr_key         = pool[$urandom_range(0, 3)];
      wr_mask        = ($urandom_range(0, 1) == 0) ? '0 : CW'($urandom_range(0, 255));
      wr_data        = {$urandom, $urandom};
      wr_entry_valid = ($urandom_range(0, 7) != 0);
      flush_req      = ($urandom_range(0, 99) == 0);
      counters_clr   = ($urandom_range(0, 49) == 0);
      applyStimulus();
    end
    idle_inputs();
    for (int c = 0; c < 40 && busy; c++) applyStimulus();
    chk("rand_idle", 64'(busy), 64'd0);

    // Flush of a full table
    for (int a = 0; a < NE; a++) begin
      fk[a] = rand_key();
      write_entry(a, fk[a], '0, {$urandom, $urandom}, 1'b1);
    end
    flush_req = 1'b1;
    applyStimulus();
    flush_req = 1'b0;
    busy_cycles = busy ? 1 : 0;
    wr_ack_seen = 0;
    for (int c = 0; c < 40; c++) begin
      wr_req = (c == 3); wr_addr = '0; wr_key = fk[0]; wr_mask = '0;
      wr_data = 64'hDEAD; wr_entry_valid = 1'b1;
      lookup_req = 1'b1; lookup_key = fk[(c + 20) % NE];
      applyStimulus();
      if (busy) busy_cycles++;
      if (wr_ack) wr_ack_seen++;
    end
    idle_inputs();
    chk("flush_busy_cycles", 64'(busy_cycles), 64'd32);
    chk("flush_no_wr_ack",   64'(wr_ack_seen), 64'd0);
    for (int a = 0; a < NE; a++) begin
      lookup(fk[a]);
      applyStimulus();
      chk("post_flush_miss", 64'(lookup_hit), 64'd0);
    end

    // Reset in the middle of a flush with a lookup in flight
    z = rand_key();
    write_entry(30, z, '0, 64'h3030, 1'b1);
    lookup(z);
    applyStimulus();
    chk("pre_rst_hit", 64'(lookup_hit), 64'd1);
    flush_req = 1'b1;
    applyStimulus();
    flush_req = 1'b0;
    idle_cycles(4);
    lookup(z);
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack",  64'(lookup_ack), 64'd0);
    applyStimulus();
    chk("rst_inflight_dropped", 64'(lookup_ack), 64'd0);
    lookup(z);
    applyStimulus();
    chk("post_rst_ack",  64'(lookup_ack), 64'd1);
    chk("post_rst_miss", 64'(lookup_hit), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
